// File: rtl/control_unit_pkg.sv
// Shared constants for the frame-processing control unit: state encodings
// and the mode encodings driven toward the window buffer, SRAM and address calculators.
package control_unit_pkg;

  localparam int STATE_W = 5;

  localparam logic [4:0] S_IDLE     = 5'd0;
  localparam logic [4:0] S_FR_RD    = 5'd1;
  localparam logic [4:0] S_FR_WAIT  = 5'd2;
  localparam logic [4:0] S_FR_WR    = 5'd3;
  localparam logic [4:0] S_FR_UPD   = 5'd4;
  localparam logic [4:0] S_ROW_J    = 5'd5;
  localparam logic [4:0] S_FC_SRD   = 5'd6;
  localparam logic [4:0] S_FC_SWAIT = 5'd7;
  localparam logic [4:0] S_FC_WB1   = 5'd8;
  localparam logic [4:0] S_FC_DRD   = 5'd9;
  localparam logic [4:0] S_FC_DWAIT = 5'd10;
  localparam logic [4:0] S_FC_WB3   = 5'd11;
  localparam logic [4:0] S_FC_UPD   = 5'd12;
  localparam logic [4:0] S_AC_SRD   = 5'd13;
  localparam logic [4:0] S_AC_SWAIT = 5'd14;
  localparam logic [4:0] S_AC_WB2   = 5'd15;
  localparam logic [4:0] S_AC_DRD   = 5'd16;
  localparam logic [4:0] S_AC_DWAIT = 5'd17;
  localparam logic [4:0] S_AC_WB4   = 5'd18;
  localparam logic [4:0] S_AC_OUT   = 5'd19;
  localparam logic [4:0] S_AC_WUPD  = 5'd20;
  localparam logic [4:0] S_AC_SHFT  = 5'd21;
  localparam logic [4:0] S_DONE     = 5'd22;

  localparam logic [2:0] WB_NOP  = 3'd0;
  localparam logic [2:0] WB_S1   = 3'd1;
  localparam logic [2:0] WB_S2   = 3'd2;
  localparam logic [2:0] WB_SD3  = 3'd3;
  localparam logic [2:0] WB_SD4  = 3'd4;
  localparam logic [2:0] WB_SHFT = 3'd5;

  localparam logic SRAM_READ      = 1'b1;
  localparam logic SRAM_WRITE     = 1'b0;
  localparam logic ADDR_ROWCACHE  = 1'b1;
  localparam logic ADDR_OUTPUTARR = 1'b0;
  localparam logic SDRAM_READ     = 1'b1;
  localparam logic SDRAM_WRITE    = 1'b0;

endpackage

// File: rtl/control_unit.sv
// Moore FSM sequencing frame load, first-column and remaining-column passes; outputs follow state by 0 cycles.
// No backpressure: waits only on SRAM/SDRAM data-valid. CONTROL_UNIT_STATE_DBG_EN exposes state_dbg.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_flag,
  input  logic       dataRead_sram,
  input  logic       dataRead_sdram,
  input  logic       rollover_i,
  input  logic       rollover_j,
  input  logic       rollover_i_wr,
  output logic       enable_i,
  output logic       enable_j,
  output logic       enable_i_wr,
  output logic       enable_addr_calc_sram,
  output logic       enable_addr_calc_sdram,
  output logic       enable_WB,
  output logic       enable_sram,
  output logic       read_en_sdram,
  output logic       write_en_sdram,
  output logic       mode_addr_calc_sram,
  output logic       mode_addr_calc_sdram,
  output logic [2:0] mode_WB,
  output logic       mode_sram,
`ifdef CONTROL_UNIT_STATE_DBG_EN
  output logic [STATE_W-1:0] state_dbg,
`endif
  output logic       finish_flag
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  // The output-column rollover is tracked by the counter block itself; the FSM never branches on it.
  logic unused_rollover_i_wr;
  assign unused_rollover_i_wr = rollover_i_wr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_flag) state_d = S_FR_RD;
      S_FR_RD:    state_d = dataRead_sdram ? S_FR_WR : S_FR_WAIT;
      S_FR_WAIT:  if (dataRead_sdram) state_d = S_FR_WR;
      S_FR_WR:    state_d = S_FR_UPD;
      S_FR_UPD:   state_d = rollover_i ? S_ROW_J : S_FR_RD;
      S_ROW_J:    state_d = rollover_j ? S_DONE : S_FC_SRD;
      S_FC_SRD:   state_d = S_FC_SWAIT;
      S_FC_SWAIT: if (dataRead_sram) state_d = S_FC_WB1;
      S_FC_WB1:   state_d = S_FC_DRD;
      S_FC_DRD:   state_d = S_FC_DWAIT;
      S_FC_DWAIT: if (dataRead_sdram) state_d = S_FC_WB3;
      S_FC_WB3:   state_d = S_FC_UPD;
      S_FC_UPD:   state_d = S_AC_SRD;
      S_AC_SRD:   state_d = S_AC_SWAIT;
      S_AC_SWAIT: if (dataRead_sram) state_d = S_AC_WB2;
      S_AC_WB2:   state_d = S_AC_DRD;
      S_AC_DRD:   state_d = S_AC_DWAIT;
      S_AC_DWAIT: if (dataRead_sdram) state_d = S_AC_WB4;
      S_AC_WB4:   state_d = S_AC_OUT;
      S_AC_OUT:   state_d = S_AC_WUPD;
      S_AC_WUPD:  state_d = S_AC_SHFT;
      S_AC_SHFT:  state_d = rollover_i ? S_ROW_J : S_AC_SRD;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    enable_i               = 1'b0;
    enable_j               = 1'b0;
    enable_i_wr            = 1'b0;
    enable_addr_calc_sram  = 1'b0;
    enable_addr_calc_sdram = 1'b0;
    enable_WB              = 1'b0;
    enable_sram            = 1'b0;
    read_en_sdram          = 1'b0;
    write_en_sdram         = 1'b0;
    mode_addr_calc_sram    = ADDR_ROWCACHE;
    mode_addr_calc_sdram   = SDRAM_READ;
    mode_WB                = WB_NOP;
    mode_sram              = SRAM_WRITE;
    finish_flag            = 1'b0;
    case (state_q)
      S_FR_RD, S_FC_DRD, S_AC_DRD: read_en_sdram = 1'b1;
      S_FR_WR: begin
        enable_sram         = 1'b1;
        mode_sram           = SRAM_WRITE;
        mode_addr_calc_sram = ADDR_ROWCACHE;
      end
      S_FR_UPD, S_FC_UPD: begin
        enable_i               = 1'b1;
        enable_addr_calc_sram  = 1'b1;
        enable_addr_calc_sdram = 1'b1;
      end
      S_ROW_J: enable_j = 1'b1;
      S_FC_SRD, S_AC_SRD: begin
        enable_sram = 1'b1;
        mode_sram   = SRAM_READ;
      end
      S_FC_WB1: begin
        enable_WB = 1'b1;
        mode_WB   = WB_S1;
      end
      S_AC_WB2: begin
        enable_WB = 1'b1;
        mode_WB   = WB_S2;
      end
      // Window-buffer load of SDRAM data doubles as the SRAM row-cache writeback.
      S_FC_WB3, S_AC_WB4: begin
        enable_WB   = 1'b1;
        mode_WB     = (state_q == S_FC_WB3) ? WB_SD3 : WB_SD4;
        enable_sram = 1'b1;
        mode_sram   = SRAM_WRITE;
      end
      S_AC_OUT: begin
        write_en_sdram       = 1'b1;
        mode_addr_calc_sdram = SDRAM_WRITE;
      end
      S_AC_WUPD: begin
        enable_i_wr            = 1'b1;
        enable_addr_calc_sdram = 1'b1;
        mode_addr_calc_sdram   = SDRAM_WRITE;
      end
      S_AC_SHFT: begin
        enable_WB              = 1'b1;
        mode_WB                = WB_SHFT;
        enable_i               = 1'b1;
        enable_addr_calc_sram  = 1'b1;
        enable_addr_calc_sdram = 1'b1;
      end
      S_DONE: finish_flag = 1'b1;
      default: ;
    endcase
  end

`ifdef CONTROL_UNIT_STATE_DBG_EN
  assign state_dbg = state_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Drives randomized frames through control_unit and compares every cycle's outputs
// against a frame-walk model built from column/row counts and random wait lengths.
module tb_control_unit;

  typedef struct packed {
    logic       en_i;
    logic       en_j;
    logic       en_iwr;
    logic       eas;
    logic       ead;
    logic       ewb;
    logic [2:0] mwb;
    logic       esr;
    logic       msr;
    logic       masr;
    logic       masd;
    logic       rd;
    logic       wr;
    logic       fin;
  } outs_t;

  localparam int X = 2;  // "don't care": drive random noise

  logic clk = 1'b0;
  logic n_rst;
  logic start_flag, dataRead_sram, dataRead_sdram;
  logic rollover_i, rollover_j, rollover_i_wr;
  logic enable_i, enable_j, enable_i_wr, enable_addr_calc_sram, enable_addr_calc_sdram;
  logic enable_WB, enable_sram, read_en_sdram, write_en_sdram;
  logic mode_addr_calc_sram, mode_addr_calc_sdram, mode_sram, finish_flag;
  logic [2:0] mode_WB;
`ifdef CONTROL_UNIT_STATE_DBG_EN
  logic [4:0] state_dbg;
`endif

  int n_checks = 0;
  int n_err    = 0;

  outs_t e_idle, e_rd, e_frwr, e_upd, e_rowj, e_srd, e_wb1, e_wb2, e_wb3, e_wb4;
  outs_t e_out, e_wupd, e_shft, e_done;
  outs_t obs;

  always #5 clk = ~clk;

  control_unit dut (
    .clk                    (clk),
    .n_rst                  (n_rst),
    .start_flag             (start_flag),
    .dataRead_sram          (dataRead_sram),
    .dataRead_sdram         (dataRead_sdram),
    .rollover_i             (rollover_i),
    .rollover_j             (rollover_j),
    .rollover_i_wr          (rollover_i_wr),
    .enable_i               (enable_i),
    .enable_j               (enable_j),
    .enable_i_wr            (enable_i_wr),
    .enable_addr_calc_sram  (enable_addr_calc_sram),
    .enable_addr_calc_sdram (enable_addr_calc_sdram),
    .enable_WB              (enable_WB),
    .enable_sram            (enable_sram),
    .read_en_sdram          (read_en_sdram),
    .write_en_sdram         (write_en_sdram),
    .mode_addr_calc_sram    (mode_addr_calc_sram),
    .mode_addr_calc_sdram   (mode_addr_calc_sdram),
    .mode_WB                (mode_WB),
    .mode_sram              (mode_sram),
`ifdef CONTROL_UNIT_STATE_DBG_EN
    .state_dbg              (state_dbg),
`endif
    .finish_flag            (finish_flag)
  );

  assign obs = '{en_i: enable_i, en_j: enable_j, en_iwr: enable_i_wr,
                 eas: enable_addr_calc_sram, ead: enable_addr_calc_sdram,
                 ewb: enable_WB, mwb: mode_WB, esr: enable_sram, msr: mode_sram,
                 masr: mode_addr_calc_sram, masd: mode_addr_calc_sdram,
                 rd: read_en_sdram, wr: write_en_sdram, fin: finish_flag};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic pick(input int v);
    return (v == X) ? 1'($urandom_range(0, 1)) : 1'(v);
  endfunction

  // One cycle: drive inputs seen at the next rising edge, then check the current (Moore) outputs.
  task automatic cyc(input string tag, input outs_t e, input int st, input int sd,
                     input int sr, input int ri, input int rj);
    @(negedge clk);
    start_flag     = pick(st);
    dataRead_sdram = pick(sd);
    dataRead_sram  = pick(sr);
    rollover_i     = pick(ri);
    rollover_j     = pick(rj);
    rollover_i_wr  = pick(X);
    chk(tag, obs, e);
  endtask

  task automatic build_expect();
    e_idle = '0;
    e_idle.masr = 1'b1;
    e_idle.masd = 1'b1;
    e_rd   = e_idle; e_rd.rd = 1'b1;
    e_frwr = e_idle; e_frwr.esr = 1'b1;
    e_upd  = e_idle; e_upd.en_i = 1'b1; e_upd.eas = 1'b1; e_upd.ead = 1'b1;
    e_rowj = e_idle; e_rowj.en_j = 1'b1;
    e_srd  = e_idle; e_srd.esr = 1'b1; e_srd.msr = 1'b1;
    e_wb1  = e_idle; e_wb1.ewb = 1'b1; e_wb1.mwb = 3'd1;
    e_wb2  = e_idle; e_wb2.ewb = 1'b1; e_wb2.mwb = 3'd2;
    e_wb3  = e_idle; e_wb3.ewb = 1'b1; e_wb3.mwb = 3'd3; e_wb3.esr = 1'b1;
    e_wb4  = e_idle; e_wb4.ewb = 1'b1; e_wb4.mwb = 3'd4; e_wb4.esr = 1'b1;
    e_out  = e_idle; e_out.wr = 1'b1; e_out.masd = 1'b0;
    e_wupd = e_idle; e_wupd.en_iwr = 1'b1; e_wupd.ead = 1'b1; e_wupd.masd = 1'b0;
    e_shft = e_upd;  e_shft.ewb = 1'b1; e_shft.mwb = 3'd5;
    e_done = e_idle; e_done.fin = 1'b1;
  endtask

  function automatic int wlen(input bit directed);
    return directed ? 0 : int'($urandom_range(0, 2));
  endfunction

  // Column pass: SRAM read, S-strobe, SDRAM read, SD-strobe; waits sized by random extra cycles.
  task automatic col_pass(input bit first, input bit directed, input bit abort, output bit aborted);
    int w;
    aborted = 1'b0;
    cyc(first ? "fc_srd" : "ac_srd", e_srd, X, X, X, X, X);
    w = wlen(directed);
    for (int k = 0; k <= w; k++) cyc("swait", e_idle, X, X, (k == w) ? 1 : 0, X, X);
    cyc(first ? "fc_wb1" : "ac_wb2", first ? e_wb1 : e_wb2, X, X, X, X, X);
    cyc("drd", e_rd, X, X, X, X, X);
    if (abort) begin
      cyc("dwait", e_idle, X, 0, X, X, X);
      aborted = 1'b1;
      return;
    end
    w = wlen(directed);
    for (int k = 0; k <= w; k++) cyc("dwait", e_idle, X, (k == w) ? 1 : 0, X, X, X);
    cyc(first ? "fc_wb3" : "ac_wb4", first ? e_wb3 : e_wb4, X, X, X, X, X);
  endtask

  task automatic run_frame(input int cols, input int nrows, input bit directed, input bit abort);
    int w;
    bit ab;
    cyc("idle_start", e_idle, 1, X, X, X, X);
    for (int c = 0; c < cols; c++) begin
      w = directed ? ((c == 0) ? 3 : 0) : int'($urandom_range(0, 3));
      cyc("fr_rd", e_rd, X, (w == 0) ? 1 : 0, X, X, X);
      for (int k = 1; k <= w; k++) cyc("fr_wait", e_idle, X, (k == w) ? 1 : 0, X, X, X);
      cyc("fr_wr", e_frwr, X, X, X, X, X);
      cyc("fr_upd", e_upd, X, X, X, (c == cols - 1) ? 1 : 0, X);
    end
    for (int r = 0; r <= nrows; r++) begin
      cyc("row_j", e_rowj, X, X, X, X, (r == nrows) ? 1 : 0);
      if (r == nrows) break;
      col_pass(1'b1, directed, abort, ab);
      if (ab) return;
      cyc("fc_upd", e_upd, X, X, X, X, X);
      for (int c = 1; c < cols; c++) begin
        col_pass(1'b0, directed, 1'b0, ab);
        cyc("ac_out", e_out, X, X, X, X, X);
        cyc("ac_wupd", e_wupd, X, X, X, X, X);
        cyc("ac_shft", e_shft, X, X, X, (c == cols - 1) ? 1 : 0, X);
      end
    end
    cyc("done", e_done, X, X, X, X, X);
  endtask

  initial begin
    build_expect();
    n_rst = 1'b0;
    start_flag = 1'b0; dataRead_sram = 1'b0; dataRead_sdram = 1'b0;
    rollover_i = 1'b0; rollover_j = 1'b0; rollover_i_wr = 1'b0;
    #1 chk("reset", obs, e_idle);
    @(negedge clk);
    n_rst = 1'b1;
    for (int k = 0; k < 3; k++) cyc("idle_hold", e_idle, 0, X, X, X, X);

    run_frame(2, 1, 1'b1, 1'b0);
    cyc("idle_after", e_idle, 0, X, X, X, X);
    for (int f = 0; f < 8; f++) begin
      run_frame(int'($urandom_range(2, 4)), int'($urandom_range(1, 3)), 1'b0, 1'b0);
      cyc("idle_after", e_idle, 0, X, X, X, X);
    end

    run_frame(2, 1, 1'b0, 1'b1);
    #3 n_rst = 1'b0;
    #1 chk("midframe_reset", obs, e_idle);
    @(negedge clk);
    chk("reset_held", obs, e_idle);
    n_rst = 1'b1;
    for (int k = 0; k < 4; k++) cyc("idle_post_rst", e_idle, 0, X, X, X, X);
    run_frame(3, 2, 1'b0, 1'b0);
    cyc("idle_end", e_idle, 0, X, X, X, X);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
